// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: machine widths, the canonical NOP and the
// fetch-unit state encoding.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Multicycle instruction fetch and PC stage: holds PC/OldPC, fetches over a
// req/gnt/rvalid handshake and applies branch/jump redirects on PC commit.
// Optional fetch watchdog enabled by defining FETCH_TIMEOUT_EN.
//
// Handshake: imem_req_o rises the cycle after fetch_i is accepted in IDLE and
// stays high with imem_addr_o (= pc_o) stable until imem_gnt_i is sampled
// high; data is then accepted on the first imem_rvalid_i while in WAIT, and
// instr_valid_o pulses for one cycle afterwards. rvalid outside WAIT is dropped.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned     TIMEOUT_CYCLES = 255
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            fetch_i,
  input  logic            pc_upd_i,
  input  logic            branch_i,
  input  logic            jump_i,
  input  logic [XLEN-1:0] target_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [ILEN-1:0] imem_rdata_i,
  output logic [ILEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] old_pc_o,
  output logic            instr_valid_o,
  output logic            busy_o,
  output logic            misalign_o,
  output logic            fetch_err_o
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] old_pc_q, old_pc_d;
  logic [ILEN-1:0] instr_q, instr_d;
  logic            req_q, req_d;
  logic            busy_q, busy_d;
  logic            valid_q, valid_d;
  logic            misalign_q, misalign_d;
  logic            err_q, err_d;
  logic            expire;

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 32) ? 32 : CNT_RAW);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_hit;

  // Counter idles at zero, so it is already cleared when REQ is entered.
  always_comb begin
    cnt_d = '0;
    if (state_q != IDLE) cnt_d = cnt_q + CNT_W'(1);
  end

  assign timeout_hit = (state_q != IDLE) &&
                       ((32'(cnt_q) + 32'd1) >= 32'(TIMEOUT_CYCLES));
  // A grant or data arriving on the final cycle still wins over the watchdog.
  assign expire = timeout_hit &&
                  !((state_q == REQ && imem_gnt_i) || (state_q == WAIT && imem_rvalid_i));

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
  assign expire         = 1'b0;
`endif

  // State register and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      old_pc_q   <= RESET_PC;
      instr_q    <= NOP_INSTR;
      req_q      <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      old_pc_q   <= old_pc_d;
      instr_q    <= instr_d;
      req_q      <= req_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (fetch_i) state_d = REQ;
      REQ: begin
        if (imem_gnt_i)  state_d = WAIT;
        else if (expire) state_d = IDLE;
      end
      WAIT: begin
        if (imem_rvalid_i) state_d = IDLE;
        else if (expire)   state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    pc_d       = pc_q;
    old_pc_d   = old_pc_q;
    instr_d    = instr_q;
    valid_d    = 1'b0;
    misalign_d = 1'b0;
    err_d      = expire;
    req_d      = (state_d == REQ);
    busy_d     = (state_d != IDLE);

    // PC only moves in IDLE so the request address is stable for a whole fetch.
    if (state_q == IDLE && pc_upd_i) begin
      if (branch_i || jump_i) begin
        if (target_i[1]) misalign_d = 1'b1;
        else             pc_d       = target_i & ~XLEN'(1);
      end else begin
        pc_d = pc_q + XLEN'(4);
      end
    end

    if (state_q == WAIT && imem_rvalid_i) begin
      instr_d  = imem_rdata_i;
      old_pc_d = pc_q;
      valid_d  = 1'b1;
    end
  end

  assign imem_req_o    = req_q;
  assign imem_addr_o   = pc_q;
  assign pc_o          = pc_q;
  assign old_pc_o      = old_pc_q;
  assign instr_o       = instr_q;
  assign instr_valid_o = valid_q;
  assign busy_o        = busy_q;
  assign misalign_o    = misalign_q;
  assign fetch_err_o   = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit; the watchdog scenario is added
// when FETCH_TIMEOUT_EN is defined.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        fetch_i = 1'b0;
  logic        pc_upd_i = 1'b0;
  logic        branch_i = 1'b0;
  logic        jump_i = 1'b0;
  logic [31:0] target_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] old_pc_o;
  logic        instr_valid_o;
  logic        busy_o;
  logic        misalign_o;
  logic        fetch_err_o;

  fetch_unit #(
    .RESET_PC      (RESET_PC),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .fetch_i      (fetch_i),
    .pc_upd_i     (pc_upd_i),
    .branch_i     (branch_i),
    .jump_i       (jump_i),
    .target_i     (target_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_gnt_i   (imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .instr_o      (instr_o),
    .pc_o         (pc_o),
    .old_pc_o     (old_pc_o),
    .instr_valid_o(instr_valid_o),
    .busy_o       (busy_o),
    .misalign_o   (misalign_o),
    .fetch_err_o  (fetch_err_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
  endtask

  // ---------------- reference model and scoreboard ----------------
  int          n_total = 0;
  int          n_pass  = 0;
  int          err_seen = 0;
  logic [31:0] m_pc = RESET_PC;
  logic [63:0] exp_q[$];  // {old_pc, instr} per expected instr_valid_o pulse
  logic [31:0] mis_q[$];  // pc expected while misalign_o pulses

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  // Instruction memory contents: a fixed scramble of the address; word 0 is addi x1,x0,5.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0050_0093;
  endfunction

  // Architectural effect of a PC commit in IDLE.
  task automatic model_upd(input bit br, input bit jp, input logic [31:0] tgt);
    if (br || jp) begin
      if (tgt[1]) mis_q.push_back(m_pc);
      else        m_pc = {tgt[31:1], 1'b0};
    end else begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  // Monitor: pops expectations whenever the DUT signals an event.
  always @(negedge clk) begin
    if (!rst_i) begin
      if (instr_valid_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_instr_valid", 32'd1, 32'd0);
        end else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          check("instr", instr_o, e[31:0]);
          check("old_pc", old_pc_o, e[63:32]);
        end
      end
      if (misalign_o) begin
        if (mis_q.size() == 0) check("unexpected_misalign", 32'd1, 32'd0);
        else check("pc_at_misalign", pc_o, mis_q.pop_front());
      end
      if (fetch_err_o) err_seen++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_ctl();
    fetch_i = 1'b0; pc_upd_i = 1'b0; branch_i = 1'b0; jump_i = 1'b0;
    imem_rvalid_i = 1'b0;
  endtask

  // Traffic that a busy unit must ignore.
  task automatic drive_noise(input bit allow_rvalid);
    fetch_i  = 1'($urandom_range(0, 1));
    pc_upd_i = 1'($urandom_range(0, 1));
    branch_i = 1'($urandom_range(0, 1));
    jump_i   = 1'($urandom_range(0, 1));
    target_i = $urandom;
    if (allow_rvalid) begin
      imem_rvalid_i = 1'($urandom_range(0, 1));
      imem_rdata_i  = $urandom;
    end
  endtask

  task automatic pc_update(input bit br, input bit jp, input logic [31:0] tgt);
    @(negedge clk);
    pc_upd_i = 1'b1; branch_i = br; jump_i = jp; target_i = tgt;
    model_upd(br, jp, tgt);
    @(negedge clk);
    clear_ctl();
    check("pc_after_update", pc_o, m_pc);
  endtask

  task automatic do_fetch(input int gd, input int rd, input bit upd, input bit br,
                          input bit jp, input logic [31:0] tgt, input bit noise);
    logic [31:0] a;
    @(negedge clk);
    fetch_i = 1'b1;
    if (upd) begin
      pc_upd_i = 1'b1; branch_i = br; jump_i = jp; target_i = tgt;
      model_upd(br, jp, tgt);
    end
    exp_q.push_back({m_pc, mem_word(m_pc)});
    @(negedge clk);
    clear_ctl();
    check("req_rise", {31'd0, imem_req_o}, 32'd1);
    check("req_addr", imem_addr_o, m_pc);
    check("busy_in_req", {31'd0, busy_o}, 32'd1);
    a = imem_addr_o;
    for (int i = 0; i < gd; i++) begin
      if (noise) drive_noise(1'b1);
      @(negedge clk);
      clear_ctl();
      check("req_held", {31'd0, imem_req_o}, 32'd1);
      check("addr_stable", imem_addr_o, m_pc);
    end
    imem_gnt_i = 1'b1;
    @(negedge clk);
    imem_gnt_i = 1'b0;
    check("req_drop", {31'd0, imem_req_o}, 32'd0);
    check("busy_in_wait", {31'd0, busy_o}, 32'd1);
    for (int i = 0; i < rd; i++) begin
      if (noise) drive_noise(1'b0);
      @(negedge clk);
      clear_ctl();
      check("pc_stable_wait", pc_o, m_pc);
    end
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = mem_word(a);
    @(negedge clk);
    imem_rvalid_i = 1'b0;
    check("valid_pulse", {31'd0, instr_valid_o}, 32'd1);
    check("busy_done", {31'd0, busy_o}, 32'd0);
    @(negedge clk);
    check("valid_single", {31'd0, instr_valid_o}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    do_reset();
    check("rst_pc", pc_o, RESET_PC);
    check("rst_old_pc", old_pc_o, RESET_PC);
    check("rst_instr", instr_o, NOP);
    check("rst_addr", imem_addr_o, RESET_PC);
    check("rst_flags", {26'd0, imem_req_o, instr_valid_o, busy_o, misalign_o, fetch_err_o, 1'b0}, 32'd0);

    // First fetch: grant immediately, data the cycle after.
    do_fetch(0, 0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);

    // Sequential, branch and jump updates, including misaligned targets and wrap.
    pc_update(1'b1, 1'b0, 32'h0000_0100);
    pc_update(1'b0, 1'b0, 32'h0000_0000);
    pc_update(1'b1, 1'b0, 32'h0000_0080);
    pc_update(1'b0, 1'b1, 32'h0000_0102);
    pc_update(1'b0, 1'b1, 32'h0000_0201);
    pc_update(1'b1, 1'b0, 32'hFFFF_FFFC);
    pc_update(1'b0, 1'b0, 32'h0000_0000);

    // Long grant stall with ignored traffic, then update and fetch in one cycle.
    do_fetch(5, 0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    do_fetch(1, 1, 1'b1, 1'b1, 1'b0, 32'h0000_0300, 1'b0);

    // Stray rvalid while idle must be dropped.
    @(negedge clk);
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_rvalid_i = 1'b0;
    check("idle_rvalid_dropped", instr_o, mem_word(32'h0000_0300));

    // Reset while in WAIT, late rvalid afterwards.
    pc_update(1'b1, 1'b0, 32'h0000_0040);
    @(negedge clk);
    fetch_i = 1'b1;
    @(negedge clk);
    fetch_i = 1'b0; imem_gnt_i = 1'b1;
    @(negedge clk);
    imem_gnt_i = 1'b0; rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
    m_pc = RESET_PC;
    @(negedge clk);
    imem_rvalid_i = 1'b0;
    check("wait_rst_instr", instr_o, NOP);
    check("wait_rst_pc", pc_o, RESET_PC);
    check("wait_rst_busy", {31'd0, busy_o}, 32'd0);
    check("wait_rst_req", {31'd0, imem_req_o}, 32'd0);
    check("wait_rst_valid", {31'd0, instr_valid_o}, 32'd0);

    // Random mix of commits and fetches.
    for (int k = 0; k < 40; k++) begin
      logic [31:0] t;
      t = $urandom;
      if ($urandom_range(0, 2) == 0) t[1] = 1'b1;
      if ($urandom_range(0, 1) == 0) begin
        pc_update(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), t);
      end else begin
        do_fetch($urandom_range(0, 4), $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), t,
                 1'($urandom_range(0, 1)));
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

`ifdef FETCH_TIMEOUT_EN
    begin
      int          n_busy;
      int          err_before;
      logic [31:0] instr_before;
      err_before   = err_seen;
      instr_before = instr_o;
      n_busy       = 0;
      @(negedge clk);
      fetch_i = 1'b1;
      @(negedge clk);
      fetch_i = 1'b0;
      for (int i = 0; i < 30 && busy_o; i++) begin
        n_busy++;
        @(negedge clk);
      end
      check("timeout_busy_cycles", n_busy, 32'd8);
      check("timeout_err_pulses", err_seen - err_before, 32'd1);
      check("timeout_instr_kept", instr_o, instr_before);
      do_fetch(0, 1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    end
`endif

    repeat (3) @(negedge clk);
    check("instr_expect_drained", exp_q.size(), 32'd0);
    check("misalign_expect_drained", mis_q.size(), 32'd0);
`ifdef FETCH_TIMEOUT_EN
    check("fetch_err_total", err_seen, 32'd1);
`else
    check("fetch_err_total", err_seen, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
